// File: rtl/branch_predict_pc.sv
// Fetch-stage PC with a direct-mapped BTB and 2-bit direction counters.
// Optional build macro: BP_PERF_COUNTERS_EN (resolve/mispredict performance counters).
module branch_predict_pc #(
  parameter int               WIDTH    = 32,
  parameter int               ENTRIES  = 64,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  output logic [WIDTH-1:0] pc_f,
  output logic             pred_taken_f,
  output logic [WIDTH-1:0] pred_target_f,
  input  logic             res_valid_e,
  input  logic             res_jalr_e,
  input  logic             res_taken_e,
  input  logic [WIDTH-1:0] res_pc_e,
  input  logic [WIDTH-1:0] res_target_e,
  input  logic             res_pred_taken_e,
  input  logic [WIDTH-1:0] res_pred_target_e,
  output logic             mispredict_e,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_mispredicts
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = WIDTH - IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [WIDTH-1:0]   target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX-1:0]   f_idx;
  logic [TAGW-1:0]  f_tag;
  logic             f_hit;
  logic [IDX-1:0]   r_idx;
  logic [TAGW-1:0]  r_tag;
  logic             r_hit;
  logic             tbl_we;
  logic [WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0] pc_next;

  // Fetch lookup reads only registered table state, so a same-cycle write is not bypassed.
  always_comb begin
    f_idx         = pc_f[IDX+1:2];
    f_tag         = pc_f[WIDTH-1:IDX+2];
    f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken_f  = f_hit && ctr_q[f_idx][1];
    pred_target_f = pred_taken_f ? target_q[f_idx] : pc_f + WIDTH'(4);
  end

  always_comb begin
    mispredict_e = res_valid_e &&
                   ((res_taken_e != res_pred_taken_e) ||
                    (res_taken_e && res_pred_taken_e && (res_target_e != res_pred_target_e)));
    redirect_pc  = res_taken_e ? res_target_e : res_pc_e + WIDTH'(4);
    if (mispredict_e)
      pc_next = redirect_pc;
    else if (stall)
      pc_next = pc_f;
    else
      pc_next = pred_target_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_f <= RESET_PC;
    else
      pc_f <= pc_next;
  end

  always_comb begin
    r_idx  = res_pc_e[IDX+1:2];
    r_tag  = res_pc_e[WIDTH-1:IDX+2];
    r_hit  = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    tbl_we = res_valid_e && !res_jalr_e && (r_hit || res_taken_e);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++)
        ctr_q[i] <= 2'b01;
    end else if (tbl_we) begin
      if (r_hit) begin
        if (res_taken_e && ctr_q[r_idx] != 2'b11)
          ctr_q[r_idx] <= ctr_q[r_idx] + 2'd1;
        else if (!res_taken_e && ctr_q[r_idx] != 2'b00)
          ctr_q[r_idx] <= ctr_q[r_idx] - 2'd1;
      end else begin
        valid_q[r_idx] <= 1'b1;
        ctr_q[r_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target carry no reset: they are only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (tbl_we && res_taken_e) begin
      tag_q[r_idx]    <= r_tag;
      target_q[r_idx] <= res_target_e;
    end
  end

`ifdef BP_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (res_valid_e)
        perf_branches <= perf_branches + 32'd1;
      if (mispredict_e)
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_pc.sv
// Self-checking bench for branch_predict_pc: directed test-plan steps, then randomized resolves vs a reference model.
module tb_branch_predict_pc;

  localparam int ENT  = 16;
  localparam int IDXB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        res_valid_e;
  logic        res_jalr_e;
  logic        res_taken_e;
  logic [31:0] res_pc_e;
  logic [31:0] res_target_e;
  logic        res_pred_taken_e;
  logic [31:0] res_pred_target_e;
  logic        mispredict_e;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  branch_predict_pc #(.WIDTH(32), .ENTRIES(ENT), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .pc_f(pc_f), .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .res_valid_e(res_valid_e), .res_jalr_e(res_jalr_e), .res_taken_e(res_taken_e),
    .res_pc_e(res_pc_e), .res_target_e(res_target_e),
    .res_pred_taken_e(res_pred_taken_e), .res_pred_target_e(res_pred_target_e),
    .mispredict_e(mispredict_e),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: the BTB as plain arrays, counters as integers 0..3.
  logic [31:0] m_pc;
  bit          m_v   [ENT];
  logic [31:0] m_tag [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_ctr [ENT];
  logic [31:0] m_br, m_mi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_br = 0;
    m_mi = 0;
    for (int i = 0; i < ENT; i++) begin
      m_v[i]   = 0;
      m_ctr[i] = 1;
      m_tag[i] = 0;
      m_tgt[i] = 0;
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % ENT);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (IDXB + 2);
  endfunction

  task automatic check_perf();
`ifdef BP_PERF_COUNTERS_EN
    chk("perf_branches", perf_branches, m_br);
    chk("perf_mispredicts", perf_mispredicts, m_mi);
`else
    chk("perf_branches_tied", perf_branches, 32'h0);
    chk("perf_mispredicts_tied", perf_mispredicts, 32'h0);
`endif
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic st, input logic rv, input logic jl, input logic tk,
                      input logic [31:0] rpc, input logic [31:0] rtgt,
                      input logic pt, input logic [31:0] ptgt);
    int          fi, ri;
    bit          e_pt, e_mis, rhit;
    logic [31:0] e_tgt, nxt;
    stall = st; res_valid_e = rv; res_jalr_e = jl; res_taken_e = tk;
    res_pc_e = rpc; res_target_e = rtgt; res_pred_taken_e = pt; res_pred_target_e = ptgt;
    #1;
    fi    = idx_of(m_pc);
    e_pt  = m_v[fi] && (m_tag[fi] == tag_of(m_pc)) && (m_ctr[fi] >= 2);
    e_tgt = e_pt ? m_tgt[fi] : m_pc + 32'd4;
    e_mis = rv && ((tk != pt) || (tk && pt && rtgt != ptgt));
    chk("pc_f", pc_f, m_pc);
    chk("pred_taken_f", {31'b0, pred_taken_f}, {31'b0, e_pt});
    chk("pred_target_f", pred_target_f, e_tgt);
    chk("mispredict_e", {31'b0, mispredict_e}, {31'b0, e_mis});
    if (e_mis)   nxt = tk ? rtgt : rpc + 32'd4;
    else if (st) nxt = m_pc;
    else         nxt = e_tgt;
    @(posedge clk);
    #1;
    m_pc = nxt;
    if (rv) m_br++;
    if (e_mis) m_mi++;
    if (rv && !jl) begin
      ri   = idx_of(rpc);
      rhit = m_v[ri] && (m_tag[ri] == tag_of(rpc));
      if (rhit) begin
        if (tk) begin
          m_ctr[ri] = (m_ctr[ri] == 3) ? 3 : m_ctr[ri] + 1;
          m_tgt[ri] = rtgt;
        end else begin
          m_ctr[ri] = (m_ctr[ri] == 0) ? 0 : m_ctr[ri] - 1;
        end
      end else if (tk) begin
        m_v[ri] = 1; m_tag[ri] = tag_of(rpc); m_tgt[ri] = rtgt; m_ctr[ri] = 2;
      end
    end
    chk("pc_next", pc_f, m_pc);
    check_perf();
    @(negedge clk);
  endtask

  task automatic idle(input logic st);
    step(st, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  // JALR redirect used to steer fetch to an arbitrary address.
  task automatic jump_to(input logic [31:0] a);
    step(0, 1, 1, 1, 32'h0000_0800, a, 0, 32'h0);
  endtask

  initial begin
    logic [31:0] rpc, rtgt, ptgt;
    logic        rv, jl, tk, pt, st;
    rst_n = 1'b0; stall = 0; res_valid_e = 0; res_jalr_e = 0; res_taken_e = 0;
    res_pc_e = 0; res_target_e = 0; res_pred_taken_e = 0; res_pred_target_e = 0;
    model_reset();
    #2;
    chk("reset_pc", pc_f, 32'h0);
    chk("reset_pred_taken", {31'b0, pred_taken_f}, 32'h0);
    chk("reset_mispredict", {31'b0, mispredict_e}, 32'h0);
    check_perf();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", pc_f, 32'(i * 4));
      idle(0);
    end

    // Taken branch 0x10 -> 0x40 predicted not taken.
    chk("at_0x10", pc_f, 32'h10);
    step(0, 1, 0, 1, 32'h10, 32'h40, 0, 32'h14);
    chk("redirect_0x40", pc_f, 32'h40);
    jump_to(32'h10);
    chk("pred_taken_0x10", {31'b0, pred_taken_f}, 32'h1);
    chk("pred_target_0x10", pred_target_f, 32'h40);

    // Two not-taken resolves: 10 -> 01 -> 00.
    step(0, 1, 0, 0, 32'h10, 32'h40, 1, 32'h40);
    chk("redirect_0x14", pc_f, 32'h14);
    step(0, 1, 0, 0, 32'h10, 32'h40, 0, 32'h14);
    jump_to(32'h10);
    chk("nt_pred_0x10", {31'b0, pred_taken_f}, 32'h0);
    chk("nt_target_0x10", pred_target_f, 32'h14);

    // JALR does not touch the table.
    step(0, 1, 1, 1, 32'h20, 32'h100, 0, 32'h24);
    chk("jalr_redirect", pc_f, 32'h100);
    jump_to(32'h20);
    chk("jalr_no_alloc", {31'b0, pred_taken_f}, 32'h0);

    // Stall does not hold a redirect; stall alone holds.
    step(1, 1, 1, 1, 32'h200, 32'h300, 0, 32'h0);
    chk("stall_redirect", pc_f, 32'h300);
    idle(1);
    idle(1);
    chk("stall_hold", pc_f, 32'h300);

    // Aliasing: 0x10 and 0x10 + 4*ENT share an index.
    step(0, 1, 0, 1, 32'h10, 32'h80, 0, 32'h14);
    step(0, 1, 0, 1, 32'h10 + 32'(4 * ENT), 32'h90, 0, 32'h54);
    jump_to(32'h10);
    chk("alias_evicted", {31'b0, pred_taken_f}, 32'h0);
    chk("alias_evicted_tgt", pred_target_f, 32'h14);
    jump_to(32'h10 + 32'(4 * ENT));
    chk("alias_new_tgt", pred_target_f, 32'h90);

    // Fetch address wraps to zero.
    jump_to(32'hFFFF_FFFC);
    idle(0);
    chk("pc_wrap", pc_f, 32'h0);

    // Reset asserted while a redirect is pending.
    idle(0);
    res_valid_e = 1; res_jalr_e = 1; res_taken_e = 1; res_pc_e = 32'h40;
    res_target_e = 32'h500; res_pred_taken_e = 0; res_pred_target_e = 32'h0;
    #1;
    chk("pre_reset_mispredict", {31'b0, mispredict_e}, 32'h1);
    #1;
    rst_n = 1'b0;
    res_valid_e = 0;
    #1;
    chk("midreset_pc", pc_f, 32'h0);
    chk("midreset_pred", {31'b0, pred_taken_f}, 32'h0);
    model_reset();
    check_perf();
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      rv   = ($urandom_range(0, 1) == 1);
      jl   = ($urandom_range(0, 3) == 0);
      tk   = jl ? 1'b1 : 1'($urandom_range(0, 1));
      rpc  = 32'($urandom_range(0, 31)) << 2;
      rtgt = 32'($urandom_range(0, 63)) << 2;
      pt   = 1'($urandom_range(0, 1));
      ptgt = ($urandom_range(0, 1) == 1) ? rtgt : 32'($urandom_range(0, 63)) << 2;
      st   = ($urandom_range(0, 3) == 0);
      step(st, rv, jl, tk, rpc, rtgt, pt, ptgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predict_pc.md
# branch_predict_pc

Parametrised fetch-stage program counter with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It sits at the front of the pipeline and drives the fetch address every cycle. It predicts taken branches at fetch, accepts resolved outcomes from execute, and issues a one-cycle-latency redirect with a flush indication on misprediction.

## Interface
- `WIDTH`, 32: address width in bits.
- `ENTRIES`, 64: number of BTB entries; power of two, minimum 4.
- `RESET_PC`, 32'h0: fetch address after reset.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall` in 1: holds the fetch PC. Redirects are not held by it.
- `pc_f` out WIDTH: current fetch address (registered).
- `pred_taken_f` out 1: prediction for `pc_f`. Pipelined down to execute by the surrounding logic.
- `pred_target_f` out WIDTH: predicted target for `pc_f`. Pipelined with `pred_taken_f`.
- `res_valid_e` in 1: a control-flow instruction is resolving in execute this cycle.
- `res_jalr_e` in 1: the resolving instruction is JALR (otherwise a branch or JAL).
- `res_taken_e` in 1: actual outcome. Always 1 for JAL/JALR.
- `res_pc_e` in WIDTH: PC of the resolving instruction.
- `res_target_e` in WIDTH: actual target (PCE+ImmOp, or Result for JALR).
- `res_pred_taken_e` in 1: the prediction carried with the instruction from fetch.
- `res_pred_target_e` in WIDTH: the predicted target carried with the instruction from fetch.
- `mispredict_e` out 1: combinational flush request for fetch/decode.
- `perf_branches` out 32: count of resolved control-flow instructions (see Configuration).
- `perf_mispredicts` out 32: count of mispredictions (see Configuration).

## Operation
- Index = `pc[IDX+1:2]` with IDX = log2(ENTRIES). Tag = `pc[WIDTH-1:IDX+2]`. Each entry holds {valid, tag, target, ctr[1:0]}.
- Fetch lookup is combinational on `pc_f`.
  - hit = valid && tag match.
  - `pred_taken_f` = hit && ctr[1].
  - `pred_target_f` = entry target when `pred_taken_f`, else `pc_f`+4.
- Mispredict, qualified by `res_valid_e`, when either holds:
  - `res_taken_e` != `res_pred_taken_e`;
  - the instruction was taken, predicted taken, and `res_target_e` != `res_pred_target_e`.
- Redirect address = `res_target_e` if taken, else `res_pc_e`+4.
- Next PC, in priority order:
  1. mispredict → redirect address;
  2. `stall` → hold;
  3. otherwise `pred_target_f`.
- Table update on `res_valid_e` when `res_jalr_e`=0:
  - Hit: ctr saturates up (taken) or down (not taken), clamped at 00 and 11. Target overwritten when taken.
  - Miss and taken: allocate with valid=1, tag, target, ctr=10 (weakly taken).
  - Miss and not taken: no change.
- JALR never reads or writes the table. It mispredicts whenever its carried prediction differs from the actual outcome/target.
- Address arithmetic is modulo 2^WIDTH. `pc_f`+4 wraps from all-ones-minus-3 to 0.

## Timing
- Reset, asynchronous:
  - `pc_f`=RESET_PC; all valid=0; all ctr=01.
  - Perf counters=0.
  - `pred_taken_f`=0 and `mispredict_e`=0, since no entries are valid and `res_valid_e` is expected low.
- Redirect latency: `mispredict_e` is asserted in cycle N; `pc_f` equals the redirect address at cycle N+1, regardless of `stall`.
- A table write in cycle N is visible to lookup from cycle N+1. A same-cycle lookup of the same index sees the old entry (no bypass).
- An `rst_n` assertion mid-redirect discards the redirect; the PC returns to RESET_PC immediately.
- `stall` with no mispredict: `pc_f`, and the prediction outputs for an unchanged table, remain constant.

## Configuration
- `BP_PERF_COUNTERS_EN` defined: `perf_branches` increments on every `res_valid_e`. `perf_mispredicts` increments on every `mispredict_e`. Both are 32-bit and wrap at 2^32.
- Not defined: both outputs are tied to 0 and no counter flops are synthesised. Prediction behaviour is identical in both builds.

## Test plan
- Reset release, no resolves, stall=0 → `pc_f` steps 0,4,8,C; `pred_taken_f`=0 throughout.
- Taken branch at 0x10 → 0x40 resolves with predicted not taken:
  - `mispredict_e`=1 and the next `pc_f`=0x40.
  - On the next fetch of 0x10, `pred_taken_f`=1 and `pred_target_f`=0x40.
- Same branch resolved not taken twice:
  - ctr goes 10→01→00.
  - The first not-taken resolve mispredicts and redirects to 0x14.
  - After that, fetch of 0x10 predicts not taken.
- JALR at 0x20, Result 0x100, predicted not taken → redirect to 0x100; the table is unchanged (lookup of 0x20 still misses).
- `stall`=1 concurrent with a mispredict → `pc_f` takes the redirect target the next cycle; stall alone holds `pc_f`.
- Two aliasing branches, 0x10 and 0x10+4·ENTRIES, both taken:
  - The second allocation replaces the first (tag change).
  - The first then misses, and its fetch predicts `pc`+4.
  - With `BP_PERF_COUNTERS_EN`, both counters match the expected totals.
